dvp_pattern_source: RTL and testbench

// - DVP (OV2640-style) sensor emulator: drives VSYNC/HREF/8-bit Y pixel data, the same signals the camera drives into the capture path.
// - Drop-in replacement for the camera on the frame-buffer input for bring-up and regression.
// - Generates selectable test patterns with exact, parameterised frame timing.

---
 rtl/dvp_pattern_source_if.sv | 25 ++
 rtl/dvp_pattern_source.sv | 192 +++++++++++++++++++
 tb/tb_dvp_pattern_source.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pattern_source_if.sv
// DVP sensor-side bundle: run control in, VSYNC/HREF/Y8 pixel stream and status out.
// Latency: n/a (wires only).
// Backpressure: none; DVP is a free-running push interface qualified by opix_valid.
interface dvp_pattern_source_if;
  logic       ienable;
  logic [1:0] imode;
  logic       ovsync;
  logic       ohref;
  logic [7:0] opixdata;
  logic       opix_valid;
  logic       obusy;
  logic [7:0] oframe_cnt;

  // Pattern source side
  modport master (
    input  ienable, imode,
    output ovsync, ohref, opixdata, opix_valid, obusy, oframe_cnt
  );

  // Capture side
  modport slave (
    output ienable, imode,
    input  ovsync, ohref, opixdata, opix_valid, obusy, oframe_cnt
  );
endinterface

// File: rtl/dvp_pattern_source.sv
// DVP camera emulator: VSYNC/HREF/Y8 test patterns with parameterised frame timing.
// Latency: outputs registered, updated together on each pixel-slot tick (every PCLK_DIV iclk).
// Backpressure: none; the stream free-runs, opix_valid qualifies each slot. V_ACT must be >= 1.
module dvp_pattern_source #(
  parameter int H_ACT    = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int PCLK_DIV = 1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  dvp_pattern_source_if.master  bus
);

  localparam int H_TOTAL = H_ACT + H_BLANK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VM1     = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int VM2     = (V_ACT > V_FRONT) ? V_ACT : V_FRONT;
  localparam int VMAX    = (VM1 > VM2) ? VM1 : VM2;
  localparam int LW      = (VMAX > 1) ? $clog2(VMAX) : 1;
  localparam int DW      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int BAR_W   = (H_ACT >= 8) ? (H_ACT / 8) : 1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  logic [DW-1:0] div_q, div_d;
  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    fnum_q, fnum_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          busy_q, busy_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    pix_q, pix_d;
  logic          pvld_q, pvld_d;

  logic          tick, line_end, phase_end;
  logic          start_frame, frame_end;
  logic [7:0]    x8, y8;
  logic [HW-1:0] bar;

  function automatic int phase_len(input state_t s);
    int r;
    case (s)
      S_VSYNC:  r = V_SYNC;
      S_VBACK:  r = V_BACK;
      S_ACTIVE: r = V_ACT;
      S_VFRONT: r = V_FRONT;
      default:  r = 1;
    endcase
    return r;
  endfunction

  // Skip over phases whose line count is zero (ACTIVE is always present).
  function automatic state_t first_phase(input state_t s);
    state_t r;
    r = s;
    if (r == S_VSYNC && V_SYNC == 0) r = S_VBACK;
    if (r == S_VBACK && V_BACK == 0) r = S_ACTIVE;
    return r;
  endfunction

  assign tick      = (div_q == DW'(PCLK_DIV - 1));
  assign line_end  = (hcnt_q == HW'(H_TOTAL - 1));
  assign phase_end = line_end && (int'(lcnt_q) == phase_len(state_q) - 1);

  // Slot divider, raster counters and frame sequencing; everything advances only on a slot tick.
  always_comb begin
    div_d       = tick ? '0 : div_q + 1'b1;
    pvld_d      = tick;
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    mode_d      = mode_q;
    fnum_d      = fnum_q;
    frame_cnt_d = frame_cnt_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    if (tick) begin
      if (state_q == S_IDLE) begin
        start_frame = bus.ienable;
      end else begin
        if (line_end) begin
          hcnt_d = '0;
          lcnt_d = lcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
        if (phase_end) begin
          lcnt_d = '0;
          case (state_q)
            S_VSYNC:  state_d = first_phase(S_VBACK);
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: begin
              if (V_FRONT > 0) state_d = S_VFRONT;
              else             frame_end = 1'b1;
            end
            default:  frame_end = 1'b1;
          endcase
        end
      end
      // A frame always runs to completion; ienable only decides whether another follows.
      if (frame_end) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (bus.ienable) begin
          start_frame = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      // Pattern and frame number are frozen for the whole frame.
      if (start_frame) begin
        state_d = first_phase(S_VSYNC);
        hcnt_d  = '0;
        lcnt_d  = '0;
        mode_d  = bus.imode;
        fnum_d  = frame_cnt_d;
        busy_d  = 1'b1;
      end
    end
  end

  // Output values for the slot being entered, so outputs line up with the registered position.
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    pix_d   = pix_q;
    x8      = 8'(hcnt_d);
    y8      = 8'(lcnt_d);
    bar     = hcnt_d / HW'(BAR_W);
    if (tick) begin
      vsync_d = (state_d == S_VSYNC) ? VS_POL : ~VS_POL;
      href_d  = (state_d == S_ACTIVE) && (int'(hcnt_d) < H_ACT);
      pix_d   = 8'h00;
      if (href_d) begin
        case (mode_d)
          2'd0:    pix_d = x8 + y8;
          2'd1:    pix_d = (int'(bar) >= 7) ? 8'hFF : 8'(bar) * 8'h24;
          2'd2:    pix_d = (x8[5] ^ y8[5]) ? 8'hFF : 8'h00;
          default: pix_d = fnum_q == fnum_d ? fnum_q : fnum_d;
        endcase
      end
    end
  end

  // State and output registers with asynchronous reset to the idle, inactive-bus condition.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      div_q       <= '0;
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      mode_q      <= 2'd0;
      fnum_q      <= 8'd0;
      frame_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      vsync_q     <= ~VS_POL;
      href_q      <= 1'b0;
      pix_q       <= 8'h00;
      pvld_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      mode_q      <= mode_d;
      fnum_q      <= fnum_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      pix_q       <= pix_d;
      pvld_q      <= pvld_d;
    end
  end

  assign bus.ovsync     = vsync_q;
  assign bus.ohref      = href_q;
  assign bus.opixdata   = pix_q;
  assign bus.opix_valid = pvld_q;
  assign bus.obusy      = busy_q;
  assign bus.oframe_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Directed bench for dvp_pattern_source: reset, pattern/timing vectors, enable drop, divider, frame wrap.
// Three DUT instances: small raster, 64-wide raster for bars, and PCLK_DIV = 3.
// Slot streams are captured on the falling edge and checked against hand-computed tables.
module tb_dvp_pattern_source;

  logic iclk = 1'b0;
  logic irst_n = 1'b0;
  always #5 iclk = ~iclk;

  dvp_pattern_source_if b0();
  dvp_pattern_source_if b1();
  dvp_pattern_source_if b2();

  dvp_pattern_source #(.H_ACT(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(4), .V_FRONT(1),
                       .PCLK_DIV(1), .VS_POL(1'b1))
    u0 (.iclk(iclk), .irst_n(irst_n), .bus(b0));
  dvp_pattern_source #(.H_ACT(64), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(4), .V_FRONT(1),
                       .PCLK_DIV(1), .VS_POL(1'b1))
    u1 (.iclk(iclk), .irst_n(irst_n), .bus(b1));
  dvp_pattern_source #(.H_ACT(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(4), .V_FRONT(1),
                       .PCLK_DIV(3), .VS_POL(1'b1))
    u2 (.iclk(iclk), .irst_n(irst_n), .bus(b2));

  typedef struct {
    int         inst;   // 0 = u0 stream, 1 = u1 stream
    int         idx;    // slot offset from the first VSYNC slot of the captured frame
    logic       vs;
    logic       href;
    logic [7:0] pix;
  } vec_t;

  int compares   = 0;
  int mismatches = 0;

  // Captured slot streams: {vsync, href, pix[7:0], busy}
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic        rec0 = 1'b0;
  logic        rec1 = 1'b0;
  logic        mon6 = 1'b0;
  int          gap6 = 0;

  always @(negedge iclk) begin
    if (rec0 && b0.opix_valid) q0.push_back({b0.ovsync, b0.ohref, b0.opixdata, b0.obusy});
    if (rec1 && b1.opix_valid) q1.push_back({b1.ovsync, b1.ohref, b1.opixdata, b1.obusy});
    if (mon6 && !b0.obusy) gap6++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_reset();
    irst_n = 1'b0;
    repeat (3) @(negedge iclk);
    irst_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vtab[$];
    int          s0, s1, nvs, nh, runs, rl, rmin, rmax, nxt, hc, bad, n, nv, per_bad, last_v, vsc;
    logic [10:0] smp;
    logic [9:0]  prev;

    // Expected slot contents. u0: H_TOTAL 20, active rows begin at slot 40.
    vtab.push_back(vec_t'{0,   0, 1'b1, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0,  19, 1'b1, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0,  20, 1'b0, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0,  40, 1'b0, 1'b1, 8'h00});
    vtab.push_back(vec_t'{0,  55, 1'b0, 1'b1, 8'h0F});
    vtab.push_back(vec_t'{0,  56, 1'b0, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0,  61, 1'b0, 1'b1, 8'h02});
    vtab.push_back(vec_t'{0,  80, 1'b0, 1'b1, 8'h02});
    vtab.push_back(vec_t'{0,  95, 1'b0, 1'b1, 8'h11});
    vtab.push_back(vec_t'{0, 119, 1'b0, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0, 139, 1'b0, 1'b0, 8'h00});
    vtab.push_back(vec_t'{0, 140, 1'b1, 1'b0, 8'h00});
    // u1: H_TOTAL 68, active rows at 136, frame 476; frame 1 bars, frame 2 checker.
    vtab.push_back(vec_t'{1, 136, 1'b0, 1'b1, 8'h00});
    vtab.push_back(vec_t'{1, 143, 1'b0, 1'b1, 8'h00});
    vtab.push_back(vec_t'{1, 144, 1'b0, 1'b1, 8'h24});
    vtab.push_back(vec_t'{1, 151, 1'b0, 1'b1, 8'h24});
    vtab.push_back(vec_t'{1, 168, 1'b0, 1'b1, 8'h90});
    vtab.push_back(vec_t'{1, 192, 1'b0, 1'b1, 8'hFF});
    vtab.push_back(vec_t'{1, 199, 1'b0, 1'b1, 8'hFF});
    vtab.push_back(vec_t'{1, 200, 1'b0, 1'b0, 8'h00});
    vtab.push_back(vec_t'{1, 372, 1'b0, 1'b1, 8'h90});
    vtab.push_back(vec_t'{1, 403, 1'b0, 1'b1, 8'hFF});
    vtab.push_back(vec_t'{1, 476, 1'b1, 1'b0, 8'h00});
    vtab.push_back(vec_t'{1, 612, 1'b0, 1'b1, 8'h00});
    vtab.push_back(vec_t'{1, 620, 1'b0, 1'b1, 8'h00});
    vtab.push_back(vec_t'{1, 644, 1'b0, 1'b1, 8'hFF});

    b0.ienable = 1'b1; b0.imode = 2'd0;
    b1.ienable = 1'b0; b1.imode = 2'd0;
    b2.ienable = 1'b0; b2.imode = 2'd0;

    // Test 1: reset held with ienable high
    irst_n = 1'b0;
    repeat (5) @(negedge iclk);
    chk("rst ovsync",     b0.ovsync, 0);
    chk("rst ohref",      b0.ohref, 0);
    chk("rst opixdata",   b0.opixdata, 0);
    chk("rst oframe_cnt", b0.oframe_cnt, 0);
    chk("rst obusy",      b0.obusy, 0);
    chk("rst opix_valid", b0.opix_valid, 0);

    // Test 2: gradient frame, then a second back-to-back frame
    q0.delete();
    rec0   = 1'b1;
    irst_n = 1'b1;
    for (int i = 0; i < 400 && b0.oframe_cnt != 8'd1; i++) @(negedge iclk);
    chk("t2 first frame counted", b0.oframe_cnt, 1);
    b0.ienable = 1'b0;
    for (int i = 0; i < 400 && b0.obusy; i++) @(negedge iclk);
    chk("t2 idle after frame 2", b0.obusy, 0);
    chk("t2 frame count", b0.oframe_cnt, 2);
    rec0 = 1'b0;
    s0 = -1;
    for (int i = 0; i < q0.size(); i++) if (q0[i][10]) begin s0 = i; break; end
    chk("t2 capture length", (s0 >= 0) && (q0.size() >= s0 + 280), 1);
    if (s0 < 0) s0 = 0;
    if (q0.size() >= s0 + 280) begin
      nvs = 0; nh = 0; runs = 0; rl = 0; rmin = 999; rmax = 0;
      for (int i = 0; i < 140; i++) begin
        smp = q0[s0 + i];
        if (smp[10]) nvs++;
        if (smp[9]) begin
          nh++; rl++;
        end else if (rl > 0) begin
          runs++;
          if (rl < rmin) rmin = rl;
          if (rl > rmax) rmax = rl;
          rl = 0;
        end
      end
      chk("t2 vsync ticks", nvs, 20);
      chk("t2 href ticks", nh, 64);
      chk("t2 href runs", runs, 4);
      chk("t2 run min", rmin, 16);
      chk("t2 run max", rmax, 16);
      for (int x = 0; x < 16; x++)
        chk($sformatf("t2 line2 x%0d", x), q0[s0 + 80 + x][8:1], 2 + x);
      nxt = -1;
      for (int i = 1; i < 280; i++)
        if (q0[s0 + i][10] && !q0[s0 + i - 1][10]) begin nxt = i; break; end
      chk("t2 frame length", nxt, 140);
      chk("t2 busy at seam", {q0[s0 + 139][0], q0[s0 + 140][0]}, 2'b11);
    end

    // Test 3: bars on the 64-wide raster, imode changed mid-frame
    pulse_reset();
    b1.imode = 2'd1; b1.ienable = 1'b1;
    q1.delete();
    rec1 = 1'b1;
    pulse_reset();
    for (int i = 0; i < 20 && !b1.obusy; i++) @(negedge iclk);
    chk("t3 start", b1.obusy, 1);
    repeat (250) @(negedge iclk);
    b1.imode = 2'd2;
    for (int i = 0; i < 1000 && b1.oframe_cnt != 8'd1; i++) @(negedge iclk);
    chk("t3 first frame counted", b1.oframe_cnt, 1);
    b1.ienable = 1'b0;
    for (int i = 0; i < 1000 && b1.obusy; i++) @(negedge iclk);
    chk("t3 idle", b1.obusy, 0);
    rec1 = 1'b0;
    s1 = 0;
    for (int i = 0; i < q1.size(); i++) if (q1[i][10]) begin s1 = i; break; end

    // Table-driven slot comparisons over the u0 and u1 captures
    for (int k = 0; k < vtab.size(); k++) begin
      int base, idx, sz;
      base = (vtab[k].inst == 0) ? s0 : s1;
      sz   = (vtab[k].inst == 0) ? q0.size() : q1.size();
      idx  = base + vtab[k].idx;
      chk($sformatf("vec%0d in range", k), idx < sz, 1);
      if (idx < sz) begin
        if (vtab[k].inst == 0) smp = q0[idx];
        else                   smp = q1[idx];
        chk($sformatf("vec%0d vsync", k), smp[10], vtab[k].vs);
        chk($sformatf("vec%0d href", k), smp[9], vtab[k].href);
        chk($sformatf("vec%0d pix", k), smp[8:1], vtab[k].pix);
      end
    end

    // Test 4: ienable dropped in the second active line
    b0.imode = 2'd0; b0.ienable = 1'b1;
    q0.delete();
    rec0 = 1'b1;
    pulse_reset();
    hc = 0;
    for (int i = 0; i < 300 && hc < 20; i++) begin
      @(negedge iclk);
      if (b0.ohref && b0.opix_valid) hc++;
    end
    chk("t4 reached line 1", hc, 20);
    b0.ienable = 1'b0;
    for (int i = 0; i < 400 && b0.obusy; i++) @(negedge iclk);
    rec0 = 1'b0;
    nh = 0; nvs = 0;
    for (int i = 0; i < q0.size(); i++) begin
      if (q0[i][9]) nh++;
      if (q0[i][10]) nvs++;
    end
    chk("t4 href ticks", nh, 64);
    chk("t4 vsync ticks", nvs, 20);
    chk("t4 obusy", b0.obusy, 0);
    chk("t4 ovsync", b0.ovsync, 0);
    chk("t4 frame count", b0.oframe_cnt, 1);
    bad = 0;
    repeat (300) begin
      @(negedge iclk);
      if ((b0.ohref && b0.opix_valid) || b0.ovsync || b0.obusy) bad++;
    end
    chk("t4 quiet after idle", bad, 0);

    // Test 5: PCLK_DIV = 3 timing on u2
    b2.ienable = 1'b1;
    pulse_reset();
    for (int i = 0; i < 20 && !b2.obusy; i++) @(negedge iclk);
    chk("t5 start", b2.obusy, 1);
    b2.ienable = 1'b0;
    n = 0; nv = 0; bad = 0; per_bad = 0; last_v = -1; vsc = 0;
    prev = {b2.ovsync, b2.ohref, b2.opixdata};
    while (b2.obusy && n < 1000) begin
      if (b2.opix_valid) begin
        nv++;
        if (last_v >= 0 && n - last_v != 3) per_bad++;
        last_v = n;
      end else if ({b2.ovsync, b2.ohref, b2.opixdata} != prev) begin
        bad++;
      end
      if (b2.ovsync) vsc++;
      prev = {b2.ovsync, b2.ohref, b2.opixdata};
      n++;
      @(negedge iclk);
    end
    chk("t5 frame iclk", n, 420);
    chk("t5 valid pulses", nv, 140);
    chk("t5 valid period", per_bad, 0);
    chk("t5 hold between ticks", bad, 0);
    chk("t5 vsync iclk", vsc, 60);

    // Test 6: 257 frames showing the frame number, counter wrap
    b0.imode = 2'd3; b0.ienable = 1'b1;
    gap6 = 0;
    pulse_reset();
    for (int f = 0; f < 257; f++) begin
      logic [7:0] pc;
      hc = 0;
      for (int i = 0; i < 200 && !(b0.ohref && b0.opix_valid); i++) @(negedge iclk);
      chk($sformatf("t6 frame %0d pixel", f), b0.opixdata, f % 256);
      if (f == 0) mon6 = 1'b1;
      if (f == 256) begin
        mon6 = 1'b0;
        b0.ienable = 1'b0;
      end else begin
        pc = b0.oframe_cnt;
        for (int i = 0; i < 200 && b0.oframe_cnt == pc; i++) @(negedge iclk);
        chk($sformatf("t6 frame %0d ended", f), b0.oframe_cnt != pc, 1);
      end
    end
    for (int i = 0; i < 300 && b0.obusy; i++) @(negedge iclk);
    chk("t6 idle", b0.obusy, 0);
    chk("t6 frame count wrap", b0.oframe_cnt, 1);
    chk("t6 no idle gap", gap6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
